// File: rtl/llr_frame_assembler_pkg.sv
// Shared definitions for the LLR frame assembler: default frame geometry and output FSM encoding.
package llr_frame_assembler_pkg;

    localparam int LLR_N_LOG2 = 4;
    localparam int LLR_Q      = 6;
    localparam int N          = 2**LLR_N_LOG2;
    localparam int FRAME_W    = N * LLR_Q;
    localparam int CNT_IDX_W  = LLR_N_LOG2;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

endpackage

// File: rtl/llr_pingpong_buffer.sv
// Two-frame ping-pong store: serial write port fills one frame while the other waits to be popped.
// A frame becomes poppable on the edge its last sample lands; a popped buffer is writable the cycle after.
module llr_pingpong_buffer #(
    parameter int n = 4,
    parameter int Q = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid_i,
    input  logic [Q-1:0]          wr_data_i,
    output logic                  wr_ready_o,
    input  logic                  pop_i,
    output logic                  rd_full_o,
    output logic [(2**n)*Q-1:0]   rd_data_o
);

    localparam int FW = (2**n) * Q;

    logic [FW-1:0] buf_q [2];
    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, rd_sel_q;
    logic [n-1:0]  wr_cnt_q;
    logic          wr_fire, wr_last;

    assign wr_ready_o = ~full_q[wr_sel_q];
    assign wr_fire    = wr_valid_i & wr_ready_o;
    assign wr_last    = (wr_cnt_q == '1);
    assign rd_full_o  = full_q[rd_sel_q];
    assign rd_data_o  = buf_q[rd_sel_q];

    // Pop and frame completion always target different buffers, so both edits can apply together.
    always_comb begin
        full_d = full_q;
        if (pop_i)
            full_d[rd_sel_q] = 1'b0;
        if (wr_fire && wr_last)
            full_d[wr_sel_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            full_q <= full_d;
            if (pop_i)
                rd_sel_q <= ~rd_sel_q;
            if (wr_fire) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (wr_last)
                    wr_sel_q <= ~wr_sel_q;
            end
        end
    end

    // Sample storage needs no reset: every slot is rewritten before its frame can be popped.
    always_ff @(posedge clk) begin
        if (wr_fire)
            buf_q[wr_sel_q][int'(wr_cnt_q) * Q +: Q] <= wr_data_i;
    end

endmodule

// File: rtl/llr_frame_assembler.sv
// Packs serial channel LLRs into 2^n-sample frames and launches each as a one-cycle strobe to the SC decoder.
// Launch lands one edge after the last sample; s_ready drops only while both ping-pong buffers hold frames.
module llr_frame_assembler
    import llr_frame_assembler_pkg::*;
#(
    parameter int n     = LLR_N_LOG2,
    parameter int Q     = LLR_Q,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [Q-1:0]          s_llr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  decoder_busy,
    input  logic                  decoder_done,
    output logic [(2**n)*Q-1:0]   channel_LLR_in,
    output logic                  channel_LLR_valid,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam int FW = (2**n) * Q;

    logic          buf_wr_rdy, buf_rd_full, launch;
    logic [FW-1:0] buf_rd_dat;

    logic [1:0]       state_q, state_d;
    logic             vld_q, vld_d;
    logic [FW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign s_ready = rst_n & buf_wr_rdy;
    assign launch  = (state_q == IDLE) & buf_rd_full & ~decoder_busy;

    llr_pingpong_buffer #(
        .n (n),
        .Q (Q)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid_i (s_valid & s_ready),
        .wr_data_i  (s_llr),
        .wr_ready_o (buf_wr_rdy),
        .pop_i      (launch),
        .rd_full_o  (buf_rd_full),
        .rd_data_o  (buf_rd_dat)
    );

    // The bus is forced to zero whenever the strobe is low.
    always_comb begin
        state_d = state_q;
        vld_d   = 1'b0;
        data_d  = '0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = LAUNCH;
                    vld_d   = 1'b1;
                    data_d  = buf_rd_dat;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            LAUNCH:    state_d = WAIT_DONE;
            WAIT_DONE: if (decoder_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign channel_LLR_in    = data_q;
    assign channel_LLR_valid = vld_q;
    assign frame_cnt         = cnt_q;

endmodule

// File: tb/tb_llr_frame_assembler.sv
// Randomised and directed bench for llr_frame_assembler against a frame-queue reference model.
module tb_llr_frame_assembler;
    import llr_frame_assembler_pkg::*;

    localparam int QW = LLR_Q;
    localparam int NL = N;
    localparam int FW = FRAME_W;
    typedef logic [FW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [QW-1:0] s_llr = '0;
    logic          s_valid = 1'b0;
    logic          decoder_busy = 1'b0;
    logic          decoder_done = 1'b0;
    logic          s_ready, channel_LLR_valid;
    frame_t        channel_LLR_in;
    logic [15:0]   frame_cnt;
    logic          s_ready_w2, valid_w2;
    frame_t        data_w2;
    logic [1:0]    frame_cnt_w2;

    always #5 clk = ~clk;

    llr_frame_assembler dut (
        .clk(clk), .rst_n(rst_n), .s_llr(s_llr), .s_valid(s_valid), .s_ready(s_ready),
        .decoder_busy(decoder_busy), .decoder_done(decoder_done),
        .channel_LLR_in(channel_LLR_in), .channel_LLR_valid(channel_LLR_valid), .frame_cnt(frame_cnt)
    );

    llr_frame_assembler #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .s_llr(s_llr), .s_valid(s_valid), .s_ready(s_ready_w2),
        .decoder_busy(decoder_busy), .decoder_done(decoder_done),
        .channel_LLR_in(data_w2), .channel_LLR_valid(valid_w2), .frame_cnt(frame_cnt_w2)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic frame_t pack(input logic [QW-1:0] s [NL]);
        frame_t f = '0;
        for (int j = 0; j < NL; j++) f[j*QW +: QW] = s[j];
        return f;
    endfunction

    // Reference model: a queue of completed frames awaiting launch, one partial frame,
    // and a decoder that is either free, receiving a strobe, or holding until done.
    frame_t        m_frames[$];
    logic [QW-1:0] m_part [NL];
    int            m_pcnt = 0;
    bit            m_pulse = 0, m_hold = 0;
    frame_t        m_pdat = '0;
    int unsigned   m_launch = 0;
    int            cyc = 0;
    bit            started = 0;
    bit            m_acc, m_lau;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (!rst_n) begin
            m_frames.delete();
            m_pcnt = 0; m_pulse = 0; m_hold = 0; m_pdat = '0; m_launch = 0;
        end else begin
            m_acc = s_valid && (m_frames.size() < 2);
            m_lau = !m_pulse && !m_hold && (m_frames.size() > 0) && !decoder_busy;
            if (m_lau) begin
                m_pdat = m_frames.pop_front();
                m_pulse = 1; m_hold = 1; m_launch++;
            end else if (m_pulse) begin
                m_pulse = 0;
            end else if (m_hold && decoder_done) begin
                m_hold = 0;
            end
            if (m_acc) begin
                m_part[m_pcnt] = s_llr;
                m_pcnt++;
                if (m_pcnt == NL) begin
                    m_frames.push_back(pack(m_part));
                    m_pcnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("s_ready", s_ready, rst_n && (m_frames.size() < 2));
            check("valid", channel_LLR_valid, m_pulse);
            check("frame_data", channel_LLR_in, m_pulse ? m_pdat : '0);
            check("frame_cnt", frame_cnt, m_launch[15:0]);
            check("frame_cnt_w2", frame_cnt_w2, m_launch[1:0]);
        end
    end

    int last_acc = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_samples(input frame_t f, input int count, input int gaps);
        int gap_left = gaps;
        for (int j = 0; j < count; j++) begin
            if (j > 0 && gap_left > 0) begin
                int g = (j == count - 1) ? gap_left : int'($urandom_range(1, 0));
                s_valid = 1'b0;
                repeat (g) tick();
                gap_left -= g;
            end
            s_valid = 1'b1;
            s_llr = f[j*QW +: QW];
            for (int w = 0; ; w++) begin
                logic acc = s_ready;
                tick();
                if (acc) break;
                if (w > 200) begin
                    check("accept_timeout", 0, 1);
                    s_valid = 1'b0;
                    return;
                end
            end
        end
        last_acc = cyc;
    endtask

    task automatic wait_launch(output int at);
        at = -1;
        for (int w = 0; w < 100; w++) begin
            if (channel_LLR_valid === 1'b1) begin
                at = cyc;
                return;
            end
            tick();
        end
        check("launch_timeout", 0, 1);
    endtask

    task automatic finish_decode();
        tick();
        decoder_done = 1'b1;
        tick();
        decoder_done = 1'b0;
    endtask

    function automatic frame_t rand_frame();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic frame_t fill_frame(input logic [QW-1:0] v);
        frame_t f = '0;
        for (int j = 0; j < NL; j++) f[j*QW +: QW] = v;
        return f;
    endfunction

    initial begin
        frame_t f1, fa, fb, fc, fg, fh, fk;
        int at, done_cyc;
        int w2_exp [5] = '{1, 2, 3, 0, 1};

        // Reset state
        tick(); tick();
        check("rst_s_ready", s_ready, 0);
        check("rst_valid", channel_LLR_valid, 0);
        check("rst_data", channel_LLR_in, 0);
        check("rst_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Ramp frame: launch timing and sample placement
        for (int j = 0; j < NL; j++) f1[j*QW +: QW] = QW'(j);
        send_samples(f1, NL, 0);
        s_valid = 1'b0;
        wait_launch(at);
        check("t1_latency", at - last_acc, 1);
        for (int j = 0; j < NL; j++) check("t1_sample", channel_LLR_in[j*QW +: QW], j);
        check("t1_cnt", frame_cnt, 1);
        tick();
        check("t1_pulse_width", channel_LLR_valid, 0);
        decoder_done = 1'b1; tick(); decoder_done = 1'b0;

        // Back-to-back frames with done withheld until both buffers fill
        fa = fill_frame(6'b000011);
        fb = fill_frame(6'b100101);
        fc = rand_frame();
        send_samples(fa, NL, 0);
        send_samples(fb, NL, 0);
        send_samples(fc, NL, 0);
        s_valid = 1'b0;
        check("t2_both_full", s_ready, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_no_relaunch", channel_LLR_valid, 0);
        end
        decoder_done = 1'b1; tick(); done_cyc = cyc; decoder_done = 1'b0;
        wait_launch(at);
        check("t2_relaunch_edge", at - done_cyc, 1);
        check("t2_frame_b", channel_LLR_in, fb);
        check("t2_cnt", frame_cnt, 3);
        check("t2_ready_after_launch", s_ready, 1);
        finish_decode();
        wait_launch(at);
        check("t2_frame_c", channel_LLR_in, fc);
        check("t2_cnt_c", frame_cnt, 4);
        finish_decode();

        // Gapped stream packs identically
        fg = rand_frame();
        send_samples(fg, NL, 8);
        s_valid = 1'b0;
        wait_launch(at);
        check("t3_gapped_frame", channel_LLR_in, fg);
        check("t3_cnt", frame_cnt, 5);
        finish_decode();

        // Busy gating and stray done in IDLE
        decoder_busy = 1'b1;
        fh = rand_frame();
        send_samples(fh, NL, 0);
        s_valid = 1'b0;
        decoder_done = 1'b1; tick(); decoder_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_busy_hold", channel_LLR_valid, 0);
        end
        check("t4_cnt_hold", frame_cnt, 5);
        decoder_busy = 1'b0;
        wait_launch(at);
        check("t4_frame", channel_LLR_in, fh);
        check("t4_cnt", frame_cnt, 6);
        finish_decode();

        // Reset mid-frame discards the partial frame
        send_samples(rand_frame(), 9, 0);
        s_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("t5_ready_in_reset", s_ready, 0);
        rst_n = 1'b1;
        #1;
        check("t5_ready_after_reset", s_ready, 1);
        check("t5_cnt_zero", frame_cnt, 0);
        fk = rand_frame();
        send_samples(fk, NL, 0);
        s_valid = 1'b0;
        wait_launch(at);
        check("t5_clean_frame", channel_LLR_in, fk);
        check("t5_cnt", frame_cnt, 1);
        finish_decode();

        // Narrow counter wraps
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            send_samples(rand_frame(), NL, 0);
            s_valid = 1'b0;
            wait_launch(at);
            check("t6_cnt_w2", frame_cnt_w2, w2_exp[i]);
            finish_decode();
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s_valid = 1'($urandom_range(1, 0));
            s_llr = QW'($urandom);
            decoder_busy = ($urandom_range(3, 0) == 0);
            decoder_done = ($urandom_range(7, 0) == 0);
            tick();
        end
        s_valid = 1'b0; decoder_busy = 1'b0; decoder_done = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
